// File: rtl/adc_pingpong_bram_writer_if.sv
// ---------------------------------------------------------------------------
// adc_pingpong_bram_writer_if
// Bundles the sample-stream handshake and the BRAM port-B write bus that the
// ping-pong writer sits between.
//   s_data/s_valid/s_ready : sample stream into the writer
//   pRAM_addrB/weB/dinB    : registered BRAM port-B write bus out of the writer
// Modports:
//   master : the writer (consumes the stream, drives the BRAM bus)
//   slave  : the environment (sample source and BRAM/arbiter side)
// ---------------------------------------------------------------------------
interface adc_pingpong_bram_writer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0]   s_data;
    logic                s_valid;
    logic                s_ready;
    logic [ADDR_W-1:0]   pRAM_addrB;
    logic [DATA_W/8-1:0] pRAM_weB;
    logic [DATA_W-1:0]   pRAM_dinB;

    modport master (
        input  s_data,
        input  s_valid,
        output s_ready,
        output pRAM_addrB,
        output pRAM_weB,
        output pRAM_dinB
    );

    modport slave (
        output s_data,
        output s_valid,
        input  s_ready,
        input  pRAM_addrB,
        input  pRAM_weB,
        input  pRAM_dinB
    );
endinterface

// File: rtl/adc_pingpong_bram_writer.sv
// ---------------------------------------------------------------------------
// adc_pingpong_bram_writer
// Writes a 64-bit ADC sample stream into a dual-port BRAM through port B,
// treating the BRAM as two ping-pong halves. A filled half is flagged in
// buf_rdy for the DMA reader, which hands it back with a buf_ack pulse.
// Ports:
//   trn_clk   : sole clock
//   trn_reset : synchronous active-high reset
//   cap_en    : capture enable (level); dropping it abandons the partial half
//   bus       : stream handshake + BRAM port-B write bus (master modport)
//   buf_rdy   : bit i set = half i full and owned by the consumer
//   buf_ack   : bit i pulse = consumer releases half i
//   cur_half  : half currently being filled
//   drop_cnt  : saturating count of samples offered while not ready
//   busy      : writer is not idle
// ---------------------------------------------------------------------------
module adc_pingpong_bram_writer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64,
    parameter int DROP_W = 16
) (
    input  logic                              trn_clk,
    input  logic                              trn_reset,
    input  logic                              cap_en,
    adc_pingpong_bram_writer_if.master        bus,
    output logic [1:0]                        buf_rdy,
    input  logic [1:0]                        buf_ack,
    output logic                              cur_half,
    output logic [DROP_W-1:0]                 drop_cnt,
    output logic                              busy
);
    localparam int HALF_W = ADDR_W - 1;
    localparam int WE_W   = DATA_W / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WAIT} writerState;

    writerState        stateReg, stateNext;
    logic [HALF_W-1:0] wptrReg;
    logic              curHalfReg;
    logic [1:0]        bufRdyReg, bufRdyNext, setHalf;
    logic [DROP_W-1:0] dropCntReg;
    logic [ADDR_W-1:0] addrReg;
    logic [WE_W-1:0]   weReg;
    logic [DATA_W-1:0] dinReg;

    logic sReady, handshake, lastWord, startCapture;

    // s_ready follows cap_en combinationally so a stop takes effect at once.
    assign sReady       = cap_en && (stateReg == ST_FILL) && !bufRdyReg[curHalfReg];
    assign handshake    = bus.s_valid && sReady;
    assign lastWord     = (wptrReg == {HALF_W{1'b1}});
    assign startCapture = (stateReg == ST_IDLE) && cap_en;

    // Per-half ownership flag: a completing fill sets it, an ack clears it.
    // Set has priority over a simultaneous ack on the same half.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gBufRdy
            assign setHalf[gi]    = handshake && lastWord && (curHalfReg == 1'(gi));
            assign bufRdyNext[gi] = setHalf[gi] || (bufRdyReg[gi] && !buf_ack[gi]);
        end
    endgenerate

    // Transitions use bufRdyNext so an ack landing this cycle lets the
    // writer move into the freed half on the very next cycle.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE: begin
                if (cap_en)
                    stateNext = ST_FILL;
            end
            ST_FILL: begin
                if (!cap_en)
                    stateNext = ST_IDLE;
                else if (handshake && lastWord)
                    stateNext = bufRdyNext[~curHalfReg] ? ST_WAIT : ST_FILL;
            end
            ST_WAIT: begin
                if (!cap_en)
                    stateNext = ST_IDLE;
                else if (!bufRdyNext[curHalfReg])
                    stateNext = ST_FILL;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge trn_clk) begin
        if (trn_reset)
            stateReg <= ST_IDLE;
        else
            stateReg <= stateNext;
    end

    always_ff @(posedge trn_clk) begin
        if (trn_reset) begin
            wptrReg    <= '0;
            curHalfReg <= 1'b0;
            bufRdyReg  <= 2'b00;
            dropCntReg <= '0;
            addrReg    <= '0;
            weReg      <= '0;
            dinReg     <= '0;
        end else begin
            bufRdyReg <= bufRdyNext;

            // Whole-word writes only: byte enables are all ones or all zeros.
            weReg <= handshake ? {WE_W{1'b1}} : '0;
            if (handshake) begin
                addrReg <= {curHalfReg, wptrReg};
                dinReg  <= bus.s_data;
            end

            if (startCapture) begin
                wptrReg    <= '0;
                curHalfReg <= 1'b0;
            end else if (handshake) begin
                wptrReg <= wptrReg + 1'b1;   // wraps to 0 after the last word
                if (lastWord)
                    curHalfReg <= ~curHalfReg;
            end

            if (startCapture)
                dropCntReg <= '0;
            else if ((stateReg != ST_IDLE) && bus.s_valid && !sReady
                     && (dropCntReg != {DROP_W{1'b1}}))
                dropCntReg <= dropCntReg + 1'b1;
        end
    end

    assign bus.s_ready    = sReady;
    assign bus.pRAM_addrB = addrReg;
    assign bus.pRAM_weB   = weReg;
    assign bus.pRAM_dinB  = dinReg;
    assign buf_rdy        = bufRdyReg;
    assign cur_half       = curHalfReg;
    assign drop_cnt       = dropCntReg;
    assign busy           = (stateReg != ST_IDLE);
endmodule
